// File: rtl/fifo_control.sv
// Purpose : pointer/flag controller for the 8-entry FIFO storage array (memoria).
// Latency : strobes are combinational from push/pop; pointers, count, flags and error update next edge; data_valid is one cycle after rd_enable.
// Backpr. : a push while full and a pop while empty are dropped, set the sticky error, and leave the opposite request unaffected.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   push, pop                write / read requests for this cycle
//   umbral_alto, umbral_bajo almost-full / almost-empty thresholds (0..depth)
//   wr_enable, rd_enable     accepted write / read strobes to the array
//   wr_ptr, rd_ptr           array write / read addresses
//   count                    occupancy (0..depth)
//   fifo_full, fifo_empty    occupancy == depth / == 0
//   almost_full              count >= umbral_alto
//   almost_empty             count <= umbral_bajo
//   error                    sticky overflow/underflow attempt, cleared by reset
//   data_valid               array read data on FIFO_data_out is valid this cycle
module fifo_control #(
    parameter int address_width = 3,
    parameter int data_width    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [address_width:0]   umbral_alto,
    input  logic [address_width:0]   umbral_bajo,
    output logic                     wr_enable,
    output logic                     rd_enable,
    output logic [address_width-1:0] wr_ptr,
    output logic [address_width-1:0] rd_ptr,
    output logic [address_width:0]   count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     error,
    output logic                     data_valid
);

    // Depth is a power of two, so the count needs one bit more than a pointer
    // and pointers wrap naturally at 2**address_width.
    localparam logic [address_width:0]   DEPTH   = {1'b1, {address_width{1'b0}}};
    localparam logic [address_width:0]   CNT_ONE = {{address_width{1'b0}}, 1'b1};
    localparam logic [address_width-1:0] PTR_ONE = {{(address_width-1){1'b0}}, 1'b1};

    // No data passes through here; the width only describes the controlled
    // array, so a non-positive value marks a mis-parameterised instance.
    if (data_width < 1) begin : g_invalid_data_width
    end

    logic [address_width-1:0] r_wr_ptr;
    logic [address_width-1:0] r_rd_ptr;
    logic [address_width:0]   r_count;
    logic                     r_error;
    logic                     r_data_valid;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;
    logic w_bad_req;

    // Flags decode only from registered count, so push/pop never reach them.
    assign w_full  = (r_count == DEPTH);
    assign w_empty = (r_count == '0);

    // Accept against the current flags; reset masks the strobes so the array
    // is never written or read while contents are being discarded.
    assign w_wr = push & ~w_full  & ~reset;
    assign w_rd = pop  & ~w_empty & ~reset;

    assign w_bad_req = (push & w_full) | (pop & w_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_error      <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // Accept gating already keeps count within 0..DEPTH.
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_bad_req) begin
                r_error <= 1'b1;
            end
            // Array read output is registered, so valid trails rd_enable by one.
            r_data_valid <= w_rd;
        end
    end

    assign wr_enable    = w_wr;
    assign rd_enable    = w_rd;
    assign wr_ptr       = r_wr_ptr;
    assign rd_ptr       = r_rd_ptr;
    assign count        = r_count;
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign almost_full  = (r_count >= umbral_alto);
    assign almost_empty = (r_count <= umbral_bajo);
    assign error        = r_error;
    assign data_valid   = r_data_valid;

endmodule

// File: doc/fifo_control.md
# fifo_control

Pointer and flag controller that sequences the 8-entry FIFO storage array (`memoria`). It turns `push`/`pop` requests into `wr_enable`, `rd_enable`, `wr_ptr` and `rd_ptr` for the array. It keeps an occupancy count and generates full, empty, almost-full and almost-empty flags against programmable thresholds. It raises a sticky error on overflow or underflow attempts and produces a valid strobe aligned with the array's registered read data.

## Interface
- `address_width`, default 3: pointer width; FIFO depth = 2**address_width (8).
- `data_width`, default 10: width of the data path being controlled; no data passes through this block.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write request for this cycle.
- `pop`  in  1  read request for this cycle.
- `umbral_alto`  in  address_width+1  almost-full threshold (0..8).
- `umbral_bajo`  in  address_width+1  almost-empty threshold (0..8).
- `wr_enable`  out  1  write strobe to the array.
- `rd_enable`  out  1  read strobe to the array.
- `wr_ptr`  out  address_width  write address to the array.
- `rd_ptr`  out  address_width  read address to the array.
- `count`  out  address_width+1  current occupancy (0..8).
- `fifo_full`  out  1  high when count == 8.
- `fifo_empty`  out  1  high when count == 0.
- `almost_full`  out  1  high when count >= umbral_alto.
- `almost_empty`  out  1  high when count <= umbral_bajo.
- `error`  out  1  sticky overflow/underflow indicator.
- `data_valid`  out  1  high the cycle the array's FIFO_data_out holds popped data.

## Operation
- Registered state: `wr_ptr`, `rd_ptr`, `count`, `error`, `data_valid`.
- Accept rules, evaluated against the current registered flags:
  - `wr_enable = push & ~fifo_full & ~reset`.
  - `rd_enable = pop & ~fifo_empty & ~reset`.
- A push while full is rejected, even when `pop` is also high. The pop still proceeds.
- A pop while empty is rejected, even when `push` is also high. The push still proceeds.
- On an accepted write, `wr_ptr` increments modulo 8 (7 -> 0).
- On an accepted read, `rd_ptr` increments modulo 8.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both or neither are accepted.
- `count` never exceeds 8 and never goes below 0.
- All flags decode combinationally from the registered `count` and the threshold inputs. They have no combinational path from `push`/`pop`.
- `error` is set on the edge following a cycle with `(push & fifo_full) | (pop & fifo_empty)`. It is cleared only by `reset`.
- `data_valid` is `rd_enable` delayed by one cycle. This matches the array's registered read output.
- On reset:
  - Registered outputs: `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0, `error` = 0, `data_valid` = 0.
  - `wr_enable` = 0, `rd_enable` = 0.
  - Decoded flags: `fifo_empty` = 1, `fifo_full` = 0, `almost_empty` = 1, `almost_full` = (umbral_alto == 0).
- Reset mid-operation discards all contents; stale array data is never flagged valid.

## Timing
- Request to strobe: combinational in the same cycle. The array writes or reads at the next rising edge.
- Pointer, count and flag updates become visible the cycle after the accepted request.
- Read data appears on FIFO_data_out one cycle after `rd_enable`, and `data_valid` is asserted in that same cycle.
- Back-to-back push or pop every cycle is supported, with no bubbles.
- Throughput is one write and one read per cycle.
- `fifo_full` asserts in the cycle after the 8th accepted write. `fifo_empty` asserts in the cycle after the last accepted read.
- Threshold inputs may change at any time; the flags follow combinationally.

## Test plan
- **Reset:** hold reset 2 cycles with push = pop = 1 -> wr_enable = rd_enable = 0, pointers 0, count 0, fifo_empty = 1, error = 0.
- **Fill and wrap:** 8 consecutive pushes from empty -> wr_ptr steps 1..7 then 0, count = 8, fifo_full = 1. Then a 9th push -> wr_enable = 0, error = 1 on the next edge, pointer and count unchanged.
- **Simultaneous push and pop at count 4:**
  - Both pointers advance, count stays 4, data_valid = 1 one cycle later.
  - At count 8 with push = pop = 1: only rd_enable = 1, and count becomes 7.
- **Underflow:** pop on empty -> rd_enable = 0, error = 1, data_valid stays 0. A simultaneous push at empty is accepted, giving count = 1.
- **Thresholds:** umbral_alto = 6, umbral_bajo = 2.
  - Pushes from empty: almost_empty drops after the 3rd push; almost_full rises after the 6th.
  - Pops in reverse restore both flags at count 5 and count 2.
- **Reset mid-operation:** at count 5 with error = 1, assert reset for 1 cycle -> all outputs return to reset values. The next push writes to address 0.
